frame_assembler: RTL and testbench
==================================

# frame_assembler

Parametrised frame builder for the UDP data path: collects indexed samples from `N_CH` channels and writes them into a double-buffered (ping-pong) frame RAM. Each frame carries a header with the sync counter, the frame number, a per-channel drop mask and per-channel sample counts. On every main-sync edge the block closes the current frame, swaps banks and pulses `o_frame_rdy`, so the packet sender can read a complete frame while the next one fills. It sits between the channel-data CDC FIFOs, already in the `clk` domain, and the UDP packet sender.

## Interface
- `N_CH`, 4: number of channels, 1..8.
- `DW`, 32: sample and RAM word width.
- `SLOTS`, 128: slots per channel, power of 2; `IW = clog2(SLOTS)+1`, so one extra index bit is available for range checking.
- `HDR_WORDS`, 16: header length; must be ≥ `N_CH+3`.
- `REVERSE`, 0: when 1, a sample with index `idx` is stored in slot `SLOTS-1-idx`.
- `AW`: derived, `clog2(HDR_WORDS + N_CH*SLOTS)`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_msync_n` in 1: main sync, active-low, already synchronous to `clk`.
- `i_sync_counter` in `DW`: sync counter value; sampled into header word 0.
- `i_ch_vld` in `N_CH`: per-channel sample valid.
- `i_ch_data` in `N_CH*DW`: samples, channel `c` at bits `[c*DW +: DW]`.
- `i_ch_idx` in `N_CH*IW`: slot index, channel `c` at bits `[c*IW +: IW]`.
- `o_ch_rdy` out `N_CH`: per-channel ready; a sample is accepted when `vld & rdy`.
- `i_rd_addr` in `AW`: read address into the idle bank.
- `o_rd_data` out `DW`: read data, 1-cycle latency.
- `o_frame_rdy` out 1: one-cycle pulse when a completed frame becomes readable.
- `o_frame_num` out `DW`: frame number of the readable bank.
- `o_sync_err` out 1: one-cycle pulse when a sync edge arrives in CLOSE or HDR.

## Operation
- **Sync detection:** `msync = prev & ~i_msync_n`, where `prev` is `i_msync_n` registered. `prev` resets to 1.
- **FSM states:** IDLE, HDR, FILL, CLOSE. Reset state is IDLE.
  - IDLE: no RAM writes; `o_ch_rdy = 0`. On `msync`, go to HDR without swapping banks.
  - HDR: runs `HDR_WORDS` cycles, writing the active bank at addresses `0..HDR_WORDS-1`. Word 0 = `i_sync_counter` sampled at the msync cycle. Word 1 = `frame_cnt`. All other words = 0. Then go to FILL.
  - FILL:
    - Round-robin arbiter: grants one channel per cycle among the channels with `vld` set, starting after the last granted channel.
    - `o_ch_rdy = grant` (one-hot, or 0 if no channel is valid); forced to 0 in the cycle `msync` is high.
    - Accepted sample, `idx < SLOTS`: write it to address `HDR_WORDS + c*SLOTS + slot` and increment `cnt[c]`.
    - Accepted sample, `idx ≥ SLOTS`: consume it, do not write it, set `drop[c]`.
    - On `msync`, go to CLOSE.
  - CLOSE: runs `N_CH+1` cycles. It writes word 2 = drop mask, zero-extended, and words `3..3+N_CH-1` = `cnt[0..N_CH-1]` into the still-active bank. On exit:
    - toggle `wr_bank`;
    - latch `o_frame_num <= frame_cnt`;
    - pulse `o_frame_rdy`;
    - increment `frame_cnt`;
    - clear `cnt` and `drop`;
    - go to HDR.
- **Sync in CLOSE or HDR:** an `msync` arriving in either state is ignored and `o_sync_err` pulses.
- **Counters:** `cnt[c]` and `frame_cnt` are `DW` bits wide and wrap modulo 2^DW. Duplicate indices overwrite the slot and still count.
- **Read port:** reads always come from bank `~wr_bank`.
- **Reset values:**
  - outputs: `o_ch_rdy = 0`, `o_frame_rdy = 0`, `o_frame_num = 0`, `o_sync_err = 0`, `o_rd_data = 0`;
  - internal: `frame_cnt = 0`, `wr_bank = 0`.
  - RAM contents are not cleared.
- **Reset mid-frame:** the partial frame is discarded and the FSM returns to IDLE; no `o_frame_rdy` is produced.

## Timing
- `msync` is high in cycle t:
  - CLOSE occupies cycles t+1 .. t+N_CH+1;
  - `o_frame_rdy` is high in cycle t+N_CH+2, with `wr_bank` already toggled;
  - HDR occupies t+N_CH+2 .. t+N_CH+HDR_WORDS+1;
  - FILL starts at t+N_CH+HDR_WORDS+2.
- Sample acceptance: the RAM write commits on the same edge; one accept per cycle at most.
- `o_rd_data` is valid 1 cycle after `i_rd_addr` is presented. A read issued in the swap cycle returns data from the new idle bank.

## Test plan
- **Header contents:** reset, msync with `i_sync_counter = 0x1234`, no samples, second msync, read words 0..4 -> `0x1234`, 0, 0, 0, 0; `o_frame_num = 0`; `o_frame_rdy` high exactly once.
- **Round-robin fairness:** all 4 channels hold `vld` for 40 FILL cycles with incrementing idx -> 10 accepts each, grant order 0,1,2,3,…; counts 10,10,10,10 in words 3..6.
- **Drop on out-of-range index:** channel 2 sends idx = 128 -> no RAM write, word 2 = `0x4`, `cnt[2]` unchanged.
- **Slot addressing and REVERSE:** with `REVERSE = 1`, channel 1 idx 0 data `0xAA` -> appears at address `16 + 128 + 127`.
- **Sync during CLOSE:** msync pulse at t+2 -> `o_sync_err` pulses, frame timing unchanged.
- **Reset mid-FILL:** assert `rst_n` low -> IDLE, all outputs 0, no `o_frame_rdy` until two further msync edges.

Source files
------------

// File: rtl/frame_assembler_if.sv
// rtl/frame_assembler_if.sv - sample, read-port and frame-status bundle for frame_assembler
interface frame_assembler_if #(
  parameter int N_CH = 4,
  parameter int DW   = 32,
  parameter int IW   = 8,
  parameter int AW   = 10
);
  logic                 i_msync_n;
  logic [DW-1:0]        i_sync_counter;
  logic [N_CH-1:0]      i_ch_vld;
  logic [N_CH*DW-1:0]   i_ch_data;
  logic [N_CH*IW-1:0]   i_ch_idx;
  logic [N_CH-1:0]      o_ch_rdy;
  logic [AW-1:0]        i_rd_addr;
  logic [DW-1:0]        o_rd_data;
  logic                 o_frame_rdy;
  logic [DW-1:0]        o_frame_num;
  logic                 o_sync_err;

  modport master (
    output i_msync_n, i_sync_counter, i_ch_vld, i_ch_data, i_ch_idx, i_rd_addr,
    input  o_ch_rdy, o_rd_data, o_frame_rdy, o_frame_num, o_sync_err
  );

  modport slave (
    input  i_msync_n, i_sync_counter, i_ch_vld, i_ch_data, i_ch_idx, i_rd_addr,
    output o_ch_rdy, o_rd_data, o_frame_rdy, o_frame_num, o_sync_err
  );
endinterface

// File: rtl/frame_assembler.sv
// rtl/frame_assembler.sv - ping-pong frame builder: header, round-robin channel fill, close and bank swap
module frame_assembler #(
  parameter int N_CH      = 4,
  parameter int DW        = 32,
  parameter int SLOTS     = 128,
  parameter int HDR_WORDS = 16,
  parameter int REVERSE   = 0,
  localparam int IW = $clog2(SLOTS) + 1,
  localparam int AW = $clog2(HDR_WORDS + N_CH*SLOTS)
) (
  input logic          clk,
  input logic          rst_n,
  frame_assembler_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HDR   = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_CLOSE = 2'd3;
  localparam int SW = $clog2(HDR_WORDS + 1);
  localparam int LW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [1:0]      state;
  logic [SW-1:0]   step;
  logic            msync_prev;
  logic            msync;
  logic            wr_bank;
  logic [DW-1:0]   frame_cnt;
  logic [DW-1:0]   sync_q;
  logic [DW-1:0]   cnt [N_CH];
  logic [N_CH-1:0] drop;
  logic [LW-1:0]   last_grant;
  logic            frame_rdy;
  logic            sync_err;
  logic [DW-1:0]   frame_num;
  logic [DW-1:0]   rd_data;
  logic [DW-1:0]   mem [2**(AW+1)];

  logic [N_CH-1:0] grant;
  logic            acc;
  logic            in_range;
  int              d;
  int              best_d;
  int              gsel;
  int              slot;
  logic [IW-1:0]   gidx;
  logic [DW-1:0]   gdata;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;

  assign msync = msync_prev & ~bus.i_msync_n;

  // Round robin: the valid channel closest after last_grant (modulo N_CH) wins.
  always_comb begin
    d      = 0;
    best_d = N_CH;
    gsel   = 0;
    gidx   = '0;
    gdata  = '0;
    for (int c = 0; c < N_CH; c++) begin
      d = (c + N_CH - 1 - int'(last_grant)) % N_CH;
      if (bus.i_ch_vld[c] && d < best_d) begin
        best_d = d;
        gsel   = c;
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      if (c == gsel) begin
        gdata = bus.i_ch_data[c*DW +: DW];
        gidx  = bus.i_ch_idx[c*IW +: IW];
      end
    end
    acc      = (best_d < N_CH) && (state == S_FILL) && !msync;
    grant    = acc ? (N_CH'(1) << gsel) : '0;
    in_range = ~gidx[IW-1];
    slot     = (REVERSE != 0) ? (SLOTS - 1 - int'(gidx[IW-2:0])) : int'(gidx[IW-2:0]);
  end

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    case (state)
      S_HDR: begin
        we    = 1'b1;
        waddr = AW'(step);
        if (step == '0)          wdata = sync_q;
        else if (step == SW'(1)) wdata = frame_cnt;
      end
      S_CLOSE: begin
        we    = 1'b1;
        waddr = AW'(step) + AW'(2);
        if (step == '0) wdata[N_CH-1:0] = drop;
        for (int c = 0; c < N_CH; c++)
          if (int'(step) == c + 1) wdata = cnt[c];
      end
      S_FILL: begin
        if (acc && in_range) begin
          we    = 1'b1;
          waddr = AW'(HDR_WORDS + gsel*SLOTS + slot);
          wdata = gdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, waddr}] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[{~wr_bank, bus.i_rd_addr}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      step       <= '0;
      msync_prev <= 1'b1;
      wr_bank    <= 1'b0;
      frame_cnt  <= '0;
      sync_q     <= '0;
      drop       <= '0;
      last_grant <= LW'(N_CH - 1);
      frame_rdy  <= 1'b0;
      sync_err   <= 1'b0;
      frame_num  <= '0;
      for (int c = 0; c < N_CH; c++) cnt[c] <= '0;
    end else begin
      msync_prev <= bus.i_msync_n;
      frame_rdy  <= 1'b0;
      sync_err   <= msync && (state == S_HDR || state == S_CLOSE);
      case (state)
        S_IDLE: begin
          if (msync) begin
            state  <= S_HDR;
            step   <= '0;
            sync_q <= bus.i_sync_counter;
          end
        end
        S_HDR: begin
          if (step == SW'(HDR_WORDS - 1)) begin
            state <= S_FILL;
            step  <= '0;
          end else begin
            step <= step + SW'(1);
          end
        end
        S_FILL: begin
          if (acc) begin
            last_grant <= LW'(gsel);
            for (int c = 0; c < N_CH; c++) begin
              if (c == gsel) begin
                if (in_range) cnt[c]  <= cnt[c] + DW'(1);
                else          drop[c] <= 1'b1;
              end
            end
          end
          if (msync) begin
            state  <= S_CLOSE;
            step   <= '0;
            sync_q <= bus.i_sync_counter;
          end
        end
        S_CLOSE: begin
          // Last status word written: hand the bank to the reader and start the next header.
          if (step == SW'(N_CH)) begin
            wr_bank   <= ~wr_bank;
            frame_num <= frame_cnt;
            frame_rdy <= 1'b1;
            frame_cnt <= frame_cnt + DW'(1);
            drop      <= '0;
            for (int c = 0; c < N_CH; c++) cnt[c] <= '0;
            state     <= S_HDR;
            step      <= '0;
          end else begin
            step <= step + SW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ch_rdy    = grant;
  assign bus.o_rd_data   = rd_data;
  assign bus.o_frame_rdy = frame_rdy;
  assign bus.o_frame_num = frame_num;
  assign bus.o_sync_err  = sync_err;
endmodule

// File: tb/tb_frame_assembler.sv
// tb/tb_frame_assembler.sv - directed bench for frame_assembler (normal and reversed slot order)
module tb_frame_assembler;
  localparam int N_CH = 4;
  localparam int DW = 32;
  localparam int SLOTS = 128;
  localparam int HDR_WORDS = 16;
  localparam int IW = 8;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  frame_assembler_if #(.N_CH(N_CH), .DW(DW), .IW(IW), .AW(AW)) ifa ();
  frame_assembler_if #(.N_CH(N_CH), .DW(DW), .IW(IW), .AW(AW)) ifb ();

  frame_assembler #(.N_CH(N_CH), .DW(DW), .SLOTS(SLOTS), .HDR_WORDS(HDR_WORDS), .REVERSE(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  frame_assembler #(.N_CH(N_CH), .DW(DW), .SLOTS(SLOTS), .HDR_WORDS(HDR_WORDS), .REVERSE(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  task automatic drive_idle;
    ifa.i_ch_vld  = '0;
    ifa.i_ch_data = '0;
    ifa.i_ch_idx  = '0;
    ifb.i_ch_vld  = '0;
    ifb.i_ch_data = '0;
    ifb.i_ch_idx  = '0;
  endtask

  task automatic put_sample(input int c, input int idx, input logic [31:0] data);
    ifa.i_ch_vld = '0;
    ifa.i_ch_vld[c] = 1'b1;
    ifa.i_ch_data[c*DW +: DW] = data;
    ifa.i_ch_idx[c*IW +: IW] = IW'(idx);
  endtask

  task automatic read_a(input int addr, output logic [31:0] d);
    ifa.i_rd_addr = AW'(addr);
    @(negedge clk);
    d = ifa.o_rd_data;
  endtask

  task automatic start_frame(input logic [31:0] sc, output int nrdy);
    ifa.i_sync_counter = sc;
    ifa.i_msync_n = 1'b0;
    nrdy = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) ifa.i_msync_n = 1'b1;
      if (ifa.o_frame_rdy) nrdy++;
    end
  endtask

  task automatic close_frame(input logic [31:0] sc, output int lat, output int nrdy);
    ifa.i_sync_counter = sc;
    ifa.i_msync_n = 1'b0;
    lat = -1;
    nrdy = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) ifa.i_msync_n = 1'b1;
      if (ifa.o_frame_rdy) begin
        nrdy++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ifa.i_msync_n = 1'b1;
    ifb.i_msync_n = 1'b1;
    ifa.i_sync_counter = '0;
    ifb.i_sync_counter = '0;
    ifa.i_rd_addr = '0;
    ifb.i_rd_addr = '0;
    drive_idle();
    repeat (3) @(negedge clk);
    checks++;
    if ({ifa.o_ch_rdy, ifa.o_frame_rdy, ifa.o_frame_num, ifa.o_sync_err, ifa.o_rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b frdy=%b fnum=%h serr=%b rd=%h required all 0",
               ifa.o_ch_rdy, ifa.o_frame_rdy, ifa.o_frame_num, ifa.o_sync_err, ifa.o_rd_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_header;
    int n, lat;
    logic [31:0] d;
    logic [31:0] exp_hdr [5] = '{32'h1234, 32'h0, 32'h0, 32'h0, 32'h0};
    start_frame(32'h1234, n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL hdr_first_sync_rdy: got %0d required 0", n); end
    close_frame(32'h5555, lat, n);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL hdr_rdy_latency: got %0d required 6", lat); end
    checks++;
    if (n !== 1) begin errors++; $display("FAIL hdr_rdy_count: got %0d required 1", n); end
    checks++;
    if (ifa.o_frame_num !== 32'd0) begin errors++; $display("FAIL hdr_frame_num: got %h required 0", ifa.o_frame_num); end
    for (int w = 0; w < 5; w++) begin
      read_a(w, d);
      checks++;
      if (d !== exp_hdr[w]) begin errors++; $display("FAIL hdr_word%0d: got %h required %h", w, d, exp_hdr[w]); end
    end
  endtask

  task automatic test_round_robin;
    int idx [N_CH];
    int n, lat;
    logic [N_CH-1:0] exp_g;
    logic [31:0] d;
    for (int c = 0; c < N_CH; c++) idx[c] = 0;
    for (int k = 0; k < 40; k++) begin
      ifa.i_ch_vld = '1;
      for (int c = 0; c < N_CH; c++) begin
        ifa.i_ch_data[c*DW +: DW] = 32'hC0DE_0000 + c*256 + idx[c];
        ifa.i_ch_idx[c*IW +: IW] = IW'(idx[c]);
      end
      #1;
      exp_g = N_CH'(1) << (k % N_CH);
      checks++;
      if (ifa.o_ch_rdy !== exp_g) begin
        errors++;
        $display("FAIL rr_grant cycle %0d: got %b required %b", k, ifa.o_ch_rdy, exp_g);
      end
      idx[k % N_CH]++;
      @(negedge clk);
    end
    drive_idle();
    close_frame(32'h6000, lat, n);
    checks++;
    if (lat !== 6 || n !== 1) begin errors++; $display("FAIL rr_rdy: lat=%0d n=%0d required 6/1", lat, n); end
    checks++;
    if (ifa.o_frame_num !== 32'd1) begin errors++; $display("FAIL rr_frame_num: got %h required 1", ifa.o_frame_num); end
    read_a(0, d);
    checks++;
    if (d !== 32'h5555) begin errors++; $display("FAIL rr_word0: got %h required 5555", d); end
    read_a(1, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL rr_word1: got %h required 1", d); end
    read_a(2, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL rr_drop_mask: got %h required 0", d); end
    for (int c = 0; c < N_CH; c++) begin
      read_a(3 + c, d);
      checks++;
      if (d !== 32'd10) begin errors++; $display("FAIL rr_cnt%0d: got %0d required 10", c, d); end
    end
    read_a(HDR_WORDS + 2*SLOTS + 5, d);
    checks++;
    if (d !== 32'hC0DE_0205) begin errors++; $display("FAIL rr_ch2_slot5: got %h required c0de0205", d); end
  endtask

  task automatic test_drop;
    int n, lat;
    logic [31:0] d;
    put_sample(3, 0, 32'hDEAD);
    #1;
    checks++;
    if (ifa.o_ch_rdy !== 4'b1000) begin errors++; $display("FAIL drop_rdy_ch3: got %b required 1000", ifa.o_ch_rdy); end
    @(negedge clk);
    put_sample(2, 128, 32'hBAD);
    #1;
    checks++;
    if (ifa.o_ch_rdy !== 4'b0100) begin errors++; $display("FAIL drop_rdy_ch2: got %b required 0100", ifa.o_ch_rdy); end
    @(negedge clk);
    put_sample(2, 3, 32'h33);
    @(negedge clk);
    put_sample(2, 3, 32'h44);
    @(negedge clk);
    drive_idle();
    close_frame(32'h7000, lat, n);
    checks++;
    if (lat !== 6 || n !== 1 || ifa.o_frame_num !== 32'd2) begin
      errors++;
      $display("FAIL drop_close: lat=%0d n=%0d fnum=%h required 6/1/2", lat, n, ifa.o_frame_num);
    end
    read_a(HDR_WORDS + 3*SLOTS, d);
    checks++;
    if (d !== 32'hDEAD) begin errors++; $display("FAIL drop_no_write: got %h required dead", d); end
    read_a(2, d);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL drop_mask: got %h required 4", d); end
    read_a(5, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL drop_cnt2: got %0d required 2", d); end
    read_a(6, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL drop_cnt3: got %0d required 1", d); end
    read_a(3, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL drop_cnt0: got %0d required 0", d); end
    read_a(HDR_WORDS + 2*SLOTS + 3, d);
    checks++;
    if (d !== 32'h44) begin errors++; $display("FAIL drop_dup_overwrite: got %h required 44", d); end
  endtask

  task automatic test_sync_during_close;
    int lat, n, elat, ne;
    ifa.i_msync_n = 1'b0;
    lat = -1; n = 0; elat = -1; ne = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ifa.o_sync_err) begin ne++; if (elat < 0) elat = k; end
      if (ifa.o_frame_rdy) begin n++; if (lat < 0) lat = k; end
      ifa.i_msync_n = (k == 2) ? 1'b0 : 1'b1;
    end
    checks++;
    if (elat !== 3 || ne !== 1) begin errors++; $display("FAIL serr_pulse: lat=%0d n=%0d required 3/1", elat, ne); end
    checks++;
    if (lat !== 6 || n !== 1) begin errors++; $display("FAIL serr_frame_timing: lat=%0d n=%0d required 6/1", lat, n); end
    checks++;
    if (ifa.o_frame_num !== 32'd3) begin errors++; $display("FAIL serr_frame_num: got %h required 3", ifa.o_frame_num); end
  endtask

  task automatic test_reverse;
    int n;
    ifb.i_msync_n = 1'b0;
    @(negedge clk);
    ifb.i_msync_n = 1'b1;
    repeat (25) @(negedge clk);
    ifb.i_ch_vld = 4'b0010;
    ifb.i_ch_data[DW +: DW] = 32'hAA;
    ifb.i_ch_idx[IW +: IW] = 8'd0;
    #1;
    checks++;
    if (ifb.o_ch_rdy !== 4'b0010) begin errors++; $display("FAIL rev_rdy: got %b required 0010", ifb.o_ch_rdy); end
    @(negedge clk);
    ifb.i_ch_data[DW +: DW] = 32'hBB;
    ifb.i_ch_idx[IW +: IW] = 8'd127;
    @(negedge clk);
    drive_idle();
    ifb.i_msync_n = 1'b0;
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      ifb.i_msync_n = 1'b1;
      if (ifb.o_frame_rdy) n++;
    end
    checks++;
    if (n !== 1) begin errors++; $display("FAIL rev_frame_rdy: got %0d required 1", n); end
    ifb.i_rd_addr = AW'(HDR_WORDS + SLOTS + 127);
    @(negedge clk);
    checks++;
    if (ifb.o_rd_data !== 32'hAA) begin errors++; $display("FAIL rev_idx0: got %h required aa", ifb.o_rd_data); end
    ifb.i_rd_addr = AW'(HDR_WORDS + SLOTS);
    @(negedge clk);
    checks++;
    if (ifb.o_rd_data !== 32'hBB) begin errors++; $display("FAIL rev_idx127: got %h required bb", ifb.o_rd_data); end
  endtask

  task automatic test_reset_mid_fill;
    int n, lat;
    logic [31:0] d;
    put_sample(0, 1, 32'h11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ifa.o_ch_rdy, ifa.o_frame_rdy, ifa.o_frame_num, ifa.o_sync_err, ifa.o_rd_data} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: rdy=%b frdy=%b fnum=%h serr=%b rd=%h required all 0",
               ifa.o_ch_rdy, ifa.o_frame_rdy, ifa.o_frame_num, ifa.o_sync_err, ifa.o_rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ifa.o_ch_rdy !== 4'b0000) begin errors++; $display("FAIL midrst_idle_rdy: got %b required 0000", ifa.o_ch_rdy); end
    @(negedge clk);
    drive_idle();
    start_frame(32'h9999, n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL midrst_first_sync_rdy: got %0d required 0", n); end
    close_frame(32'hAAAA, lat, n);
    checks++;
    if (lat !== 6 || n !== 1) begin errors++; $display("FAIL midrst_rdy: lat=%0d n=%0d required 6/1", lat, n); end
    checks++;
    if (ifa.o_frame_num !== 32'd0) begin errors++; $display("FAIL midrst_frame_num: got %h required 0", ifa.o_frame_num); end
    read_a(0, d);
    checks++;
    if (d !== 32'h9999) begin errors++; $display("FAIL midrst_word0: got %h required 9999", d); end
    read_a(1, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL midrst_word1: got %h required 0", d); end
  endtask

  initial begin
    test_reset();
    test_header();
    test_round_robin();
    test_drop();
    test_sync_during_close();
    test_reverse();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
